// File: rtl/e203_icb_resp_slave.sv
// ICB slave responder: flop scratch memory, decode-error reporting, in-order response queue with latency.
// Optional macro E203_ICB_RESP_WMASK_EN enables per-byte write masking.
module e203_icb_resp_slave #(
    parameter int            AW      = 32,
    parameter logic [AW-1:0] BASE    = 32'h1000_0000,
    parameter int            DEPTH   = 16,
    parameter int            LATENCY = 1,
    parameter int            OUTS    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic [AW-1:0] icb_cmd_addr,
    input  logic          icb_cmd_read,
    input  logic [31:0]   icb_cmd_wdata,
    input  logic [3:0]    icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic          icb_rsp_err,
    output logic [31:0]   icb_rsp_rdata,
    output logic          busy
);

    localparam int            IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            PW  = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int            CW  = $clog2(OUTS + 1);
    localparam logic [AW-1:0] WIN = AW'(DEPTH * 4);

    logic [31:0]   mem     [DEPTH];
    logic          q_err   [OUTS];
    logic [31:0]   q_rdata [OUTS];
    logic [3:0]    q_cnt   [OUTS];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [AW-1:0] off;
    logic [IW-1:0] idx;
    logic          hit, cmd_fire, head_vld, pop, wr_en;
    logic [31:0]   rd_word;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] wd,
                                               input logic [3:0] wm);
`ifdef E203_ICB_RESP_WMASK_EN
        for (int b = 0; b < 4; b++)
            merge_word[8*b +: 8] = wm[b] ? wd[8*b +: 8] : old_w[8*b +: 8];
`else
        merge_word = (wm != 4'd0) ? wd : old_w;
`endif
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        next_ptr = (p == PW'(OUTS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Offset subtraction avoids overflow of BASE+window at the top of the address space
    always_comb begin
        off      = icb_cmd_addr - BASE;
        hit      = (icb_cmd_addr >= BASE) && (off < WIN) && (icb_cmd_addr[1:0] == 2'b00);
        idx      = off[IW+1:2];
        cmd_fire = icb_cmd_valid & icb_cmd_ready;
        wr_en    = cmd_fire & hit & ~icb_cmd_read;
        rd_word  = (hit & icb_cmd_read) ? mem[idx] : 32'd0;
    end

    always_comb begin
        icb_cmd_ready = (count < CW'(OUTS));
        head_vld      = (count != '0) && (q_cnt[rd_ptr] == 4'd0);
        icb_rsp_valid = head_vld;
        icb_rsp_err   = head_vld & q_err[rd_ptr];
        icb_rsp_rdata = head_vld ? q_rdata[rd_ptr] : 32'd0;
        pop           = head_vld & icb_rsp_ready;
        busy          = (count != '0);
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (cmd_fire) wr_ptr <= next_ptr(wr_ptr);
            if (pop)      rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(cmd_fire) - CW'(pop);
        end
    end

    // Per-entry latency countdown; a freshly pushed entry restarts at LATENCY-1
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTS; i++) begin
            if (rst)
                q_cnt[i] <= 4'd0;
            else if (cmd_fire && (wr_ptr == PW'(i)))
                q_cnt[i] <= 4'(LATENCY - 1);
            else if (q_cnt[i] != 4'd0)
                q_cnt[i] <= q_cnt[i] - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            q_err[wr_ptr]   <= ~hit;
            q_rdata[wr_ptr] <= rd_word;
        end
    end

    // Scratch memory is architecturally cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (wr_en) begin
            mem[idx] <= merge_word(mem[idx], icb_cmd_wdata, icb_cmd_wmask);
        end
    end

endmodule

// File: tb/tb_e203_icb_resp_slave.sv
// Randomised scoreboard bench for e203_icb_resp_slave; expected responses come from a word-array model.
module tb_e203_icb_resp_slave;

    localparam int          AW    = 32;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 16;
    localparam int          LAT   = 3;
    localparam int          OUTS  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icb_cmd_valid = 1'b0;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr = '0;
    logic        icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_wdata = '0;
    logic [3:0]  icb_cmd_wmask = '0;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready = 1'b1;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        busy;

    e203_icb_resp_slave #(.AW(AW), .BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT), .OUTS(OUTS)) dut (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_mem [DEPTH];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          last_pop = -100;
    int          rr_until = 0;
    bit          rr_rand = 1'b0;
    bit          pend;
    int          live;
    int          due;
    bit          ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: handshake at the coming edge updates the word array and queues the answer
    always @(negedge clk) begin
        longint a;
        exp_t   e;
        int     k;
        pend = 1'b0;
        if (rst) begin
            sb.delete();
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
            last_pop = -100;
        end else begin
            check("cmd_ready", {31'd0, icb_cmd_ready}, {31'd0, sb.size() < OUTS});
            if (icb_cmd_valid && icb_cmd_ready) begin
                a       = longint'(icb_cmd_addr);
                e.acc   = cyc;
                e.err   = !(a >= longint'(BASE) && a < longint'(BASE) + DEPTH * 4 && a % 4 == 0);
                e.rdata = 32'd0;
                if (!e.err) begin
                    k = int'((a - longint'(BASE)) / 4);
                    if (icb_cmd_read) begin
                        e.rdata = mdl_mem[k];
                    end else begin
`ifdef E203_ICB_RESP_WMASK_EN
                        for (int b = 0; b < 4; b++)
                            if (icb_cmd_wmask[b]) mdl_mem[k][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
`else
                        if (icb_cmd_wmask != 4'd0) mdl_mem[k] = icb_cmd_wdata;
`endif
                    end
                end
                sb.push_back(e);
                pend = 1'b1;
            end
        end
    end

    // Monitor: response timing, contents, order and busy
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            live = sb.size() - int'(pend);
            ev   = 1'b0;
            if (live > 0) begin
                due = sb[0].acc + LAT;
                if (last_pop + 1 > due) due = last_pop + 1;
                ev = (cyc >= due);
            end
            check("rsp_valid", {31'd0, icb_rsp_valid}, {31'd0, ev});
            check("busy", {31'd0, busy}, {31'd0, live != 0});
            if (icb_rsp_valid && live > 0) begin
                check("rsp_err", {31'd0, icb_rsp_err}, {31'd0, sb[0].err});
                check("rsp_rdata", icb_rsp_rdata, sb[0].rdata);
                if (icb_rsp_ready) begin
                    void'(sb.pop_front());
                    last_pop = cyc;
                end
            end else if (!icb_rsp_valid) begin
                check("idle_err", {31'd0, icb_rsp_err}, 32'd0);
                check("idle_rdata", icb_rsp_rdata, 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (cyc < rr_until)  icb_rsp_ready = 1'b0;
        else if (rr_rand)    icb_rsp_ready = ($urandom % 4) != 0;
        else                 icb_rsp_ready = 1'b1;
    end

    task automatic idle(input int n);
        icb_cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic rd, input logic [31:0] wd, input logic [3:0] wm);
        bit ok;
        int budget;
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = addr;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        budget = 0;
        do begin
            @(negedge clk);
            ok = icb_cmd_ready;
            @(posedge clk);
            #2;
            budget++;
        end while (!ok && budget < 60);
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: addr %h not accepted within %0d cycles", addr, budget);
        end
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || busy) && budget < 200) begin
            @(posedge clk);
            #2;
            budget++;
        end
        n_chk++;
        if (sb.size() != 0 || busy) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses still expected, busy %0b", sb.size(), busy);
        end
    endtask

    initial begin
        logic [31:0] addr;
        int          k;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        issue(BASE, 1'b1, 32'd0, 4'h0);
        issue(BASE + 8, 1'b0, 32'hDEAD_BEEF, 4'hF);
        issue(BASE + 8, 1'b1, 32'd0, 4'h0);
        drain();

        issue(BASE - 4, 1'b1, 32'd0, 4'h0);
        issue(BASE + DEPTH * 4, 1'b1, 32'd0, 4'h0);
        issue(BASE + 2, 1'b1, 32'd0, 4'h0);
        issue(BASE - 4, 1'b0, 32'h1234_5678, 4'hF);
        issue(BASE + DEPTH * 4, 1'b0, 32'h1234_5678, 4'hF);
        issue(BASE + 2, 1'b0, 32'h1234_5678, 4'hF);
        for (int i = 0; i < DEPTH; i++) issue(BASE + 4 * i, 1'b1, 32'd0, 4'h0);
        drain();

        rr_until = cyc + 8;
        issue(BASE + 4, 1'b0, 32'hCAFE_0001, 4'hF);
        issue(BASE + 4, 1'b1, 32'd0, 4'h0);
        issue(BASE + 8, 1'b1, 32'd0, 4'h0);
        drain();

        issue(BASE + 12, 1'b0, 32'h1122_3344, 4'hF);
        issue(BASE + 12, 1'b0, 32'hAABB_CCDD, 4'b0101);
        issue(BASE + 12, 1'b1, 32'd0, 4'h0);
        issue(BASE + 12, 1'b0, 32'h5555_5555, 4'h0);
        issue(BASE + 12, 1'b1, 32'd0, 4'h0);
        drain();

        rr_until = cyc + 20;
        issue(BASE + 16, 1'b0, 32'h0BAD_F00D, 4'hF);
        issue(BASE + 16, 1'b1, 32'd0, 4'h0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rr_until = 0;
        issue(BASE + 16, 1'b1, 32'd0, 4'h0);
        issue(BASE + 8, 1'b1, 32'd0, 4'h0);
        drain();

        rr_rand = 1'b1;
        for (int n = 0; n < 500; n++) begin
            k    = $urandom_range(0, DEPTH + 1);
            addr = BASE + 32'(4 * k) - 32'd4;
            if ($urandom % 8 == 0) addr = addr + 32'($urandom_range(1, 3));
            issue(addr, $urandom % 2 == 0, $urandom,
                  ($urandom % 8 == 0) ? 4'h0 : 4'($urandom));
            if ($urandom % 4 == 0) idle(1 + $urandom % 3);
        end
        rr_rand = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
